// File: rtl/multiport_reg_file_pkg.sv
// Shared types and default sizing for the multiport register file.
// The top level and its read-port sub-module both import this package.
package multiport_reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/multiport_reg_file_read_port.sv
// One combinational read port: address decode, entry-0 masking, write bypass
// and enable gating. It holds no state; storage arrives flattened from the top.
module reg_file_read_port
    import multiport_reg_file_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
    input  logic                   fwd_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data
);

    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] selected;

    // NOTE: every variable gets a default before any condition, so no latch is inferred.
    always_comb begin
        stored   = '0;
        selected = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                stored = mem_flat[i*WIDTH +: WIDTH];
            end
        end
        selected = stored;
        if (BYPASS != 0 && fwd_en && wr_addr == rd_addr) begin
            selected = wr_data;
        end
        // Entry 0 masking wins over the bypass path as well.
        if (ZERO_R0 != 0 && rd_addr == '0) begin
            selected = '0;
        end
        rd_data = rd_en ? selected : '0;
    end

endmodule

// File: rtl/multiport_reg_file.sv
// One-write, two-read register file with same-cycle bypass, optional hard-zero
// entry 0 and a one-entry-per-cycle bulk clear sweep that blocks writes.
module multiport_reg_file
    import multiport_reg_file_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en1,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             rd_en2,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_drop
);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    state_e                 state_q, state_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic                   wr_drop_q, wr_drop_d;
    logic                   wr_accept;
    logic [DEPTH*WIDTH-1:0] mem_flat;

    assign busy      = (state_q == CLEAR);
    assign wr_accept = wr_en && !busy;
    assign wr_drop   = wr_drop_q;

    always_comb begin
        mem_d     = mem_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = wr_en && busy;
        case (state_q)
            IDLE: begin
                if (wr_accept && !(ZERO_R0 != 0 && wr_addr == '0)) begin
                    mem_d[wr_addr] = wr_data;
                end
                // A write in the same cycle still commits; the sweep zeroes it later.
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is plain flops and must read zero after reset, so every entry is reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
        end
    end

    reg_file_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS),
        .ZERO_R0(ZERO_R0)
    ) u_rd_port1 (
        .rd_en   (rd_en1),
        .rd_addr (rd_addr1),
        .mem_flat(mem_flat),
        .fwd_en  (wr_accept),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data1)
    );

    reg_file_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS),
        .ZERO_R0(ZERO_R0)
    ) u_rd_port2 (
        .rd_en   (rd_en2),
        .rd_addr (rd_addr2),
        .mem_flat(mem_flat),
        .fwd_en  (wr_accept),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data2)
    );

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed bench for multiport_reg_file: default build plus BYPASS=0 and
// ZERO_R0=1 builds driven by the same stimulus, with hand-computed expectations.
module tb_multiport_reg_file;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en1, rd_en2;
    logic [AW-1:0]    rd_addr1, rd_addr2;
    logic             clr_req;

    logic [WIDTH-1:0] rd_data1, rd_data2;
    logic             busy, wr_drop;
    logic [WIDTH-1:0] nb_rd_data1, nb_rd_data2;
    logic             nb_busy, nb_wr_drop;
    logic [WIDTH-1:0] z_rd_data1, z_rd_data2;
    logic             z_busy, z_wr_drop;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    multiport_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
    );

    multiport_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(0), .ZERO_R0(0)) dut_nb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(nb_rd_data1),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(nb_rd_data2),
        .clr_req(clr_req), .busy(nb_busy), .wr_drop(nb_wr_drop)
    );

    multiport_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(z_rd_data1),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(z_rd_data2),
        .clr_req(clr_req), .busy(z_busy), .wr_drop(z_wr_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd1(input logic [AW-1:0] addr);
        rd_en1   = 1'b1;
        rd_addr1 = addr;
        #1;
    endtask

    task automatic write(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en1 = 1'b0; rd_en2 = 1'b0; rd_addr1 = '0; rd_addr2 = '0; clr_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_drop", 32'(wr_drop), 32'd0);
        rd1(4'd5);
        check("reset_entry5", 32'(rd_data1), 32'h0);

        // Basic write then read, then enable gating.
        write(4'd5, 16'hBEEF);
        rd1(4'd5);
        check("rd_entry5", 32'(rd_data1), 32'hBEEF);
        rd_en1 = 1'b0;
        #1;
        check("rd_disabled", 32'(rd_data1), 32'h0000);

        // Same-cycle bypass versus stored value.
        write(4'd3, 16'h1111);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h2222;
        rd_en2 = 1'b1; rd_addr2 = 4'd3;
        rd_en1 = 1'b1; rd_addr1 = 4'd5;
        #1;
        check("bypass_on", 32'(rd_data2), 32'h2222);
        check("bypass_off", 32'(nb_rd_data2), 32'h1111);
        check("port1_indep", 32'(rd_data1), 32'hBEEF);
        tick();
        wr_en = 1'b0;
        rd_addr1 = 4'd3;
        #1;
        check("after_bypass_p1", 32'(rd_data1), 32'h2222);
        check("after_bypass_nb", 32'(nb_rd_data2), 32'h2222);
        rd_en2 = 1'b0;

        // Entry 0 hard-zero build.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        rd_en1 = 1'b1; rd_addr1 = 4'd0;
        #1;
        check("r0_same_cycle", 32'(z_rd_data1), 32'h0);
        check("r0_plain_bypass", 32'(rd_data1), 32'hFFFF);
        tick();
        wr_en = 1'b0;
        #1;
        check("r0_after", 32'(z_rd_data1), 32'h0);
        check("r0_plain_after", 32'(rd_data1), 32'hFFFF);
        check("r0_no_drop", 32'(z_wr_drop), 32'd0);

        // Full fill then a clean sweep; a second clr_req mid-sweep must not restart it.
        for (int i = 0; i < DEPTH; i++) begin
            write(AW'(i), 16'hA000 + 16'(i));
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 5) clr_req = 1'b1;
            if (n == 6) clr_req = 1'b0;
            if (n == 9) begin
                rd1(4'd15);
                check("sweep_c10_e15_old", 32'(rd_data1), 32'hA00F);
                rd1(4'd2);
                check("sweep_c10_e2_zero", 32'(rd_data1), 32'h0);
            end
            n++;
            tick();
        end
        clr_req = 1'b0;
        check("sweep_busy_cycles", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rd1(AW'(i));
            check($sformatf("swept_e%0d", i), 32'(rd_data1), 32'h0);
        end

        // Write colliding with clr_req, then a write dropped during the sweep.
        write(4'd7, 16'h7777);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1234; clr_req = 1'b1;
        tick();
        wr_en = 1'b0; clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 0) begin
                rd1(4'd9);
                check("clr_wr_committed", 32'(rd_data1), 32'h1234);
            end
            if (n == 3) begin
                rd_en2 = 1'b1; rd_addr2 = 4'd7;
                wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h5555;
                #1;
                check("busy_no_bypass", 32'(rd_data2), 32'h7777);
            end
            if (n == 4) begin
                wr_en = 1'b0;
                check("drop_pulse", 32'(wr_drop), 32'd1);
            end
            if (n == 5) check("drop_one_cycle", 32'(wr_drop), 32'd0);
            n++;
            tick();
        end
        rd_en2 = 1'b0;
        check("sweep2_busy_cycles", 32'(n), 32'd16);
        rd1(4'd7);
        check("dropped_e7_zero", 32'(rd_data1), 32'h0);
        rd1(4'd9);
        check("clr_wr_swept", 32'(rd_data1), 32'h0);

        // Reset in the middle of a sweep, with a pending write and clr_req.
        write(4'd4, 16'h4444);
        write(4'd12, 16'hC0C0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 7) begin
            n++;
            tick();
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'hABCD; clr_req = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
        #1;
        check("rst_busy_low", 32'(busy), 32'd0);
        check("rst_no_drop", 32'(wr_drop), 32'd0);
        rd1(4'd4);
        check("rst_e4_zero", 32'(rd_data1), 32'h0);
        rd1(4'd12);
        check("rst_e12_zero", 32'(rd_data1), 32'h0);
        write(4'd6, 16'h6666);
        rd1(4'd6);
        check("post_rst_write", 32'(rd_data1), 32'h6666);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/multiport_reg_file.md
MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 Parameter: WIDTH, 16, data bits per entry.
REQ-002 Parameter: DEPTH, 16, number of entries (power of two, >=2).
REQ-003 Parameter: BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-004 Parameter: ZERO_R0, 0, 1 = entry 0 reads as zero and ignores writes.
REQ-005 Derived constant: AW = clog2(DEPTH).
REQ-006 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-007 Port: rst  in  1  reset, synchronous, active-high.
REQ-008 Port: wr_en  in  1  write request.
REQ-009 Port: wr_addr  in  AW  write index.
REQ-010 Port: wr_data  in  WIDTH  write data.
REQ-011 Port: rd_en1 / rd_en2  in  1  per-port read enable.
REQ-012 Port: rd_addr1 / rd_addr2  in  AW  per-port read index.
REQ-013 Port: rd_data1 / rd_data2  out  WIDTH  per-port read data, combinational.
REQ-014 Port: clr_req  in  1  start bulk clear sweep.
REQ-015 Port: busy  out  1  high while a clear sweep is in progress.
REQ-016 Port: wr_drop  out  1  registered one-cycle pulse: a write was discarded.

Function
REQ-017 The block SHALL have no tristate outputs; rd_dataN SHALL be all-zero when rd_enN is low.
REQ-018 A write SHALL take effect at the clock edge where wr_en is high, busy is low and rst is low; the written value SHALL be readable the following cycle.
REQ-019 Reads SHALL be combinational from rd_addrN with zero-cycle latency; both ports SHALL be independent and may address the same entry.
REQ-020 With BYPASS=1, busy low, wr_en high and wr_addr==rd_addrN, rd_dataN SHALL equal wr_data in the same cycle; with BYPASS=0 it SHALL return the stored (old) value.
REQ-021 With ZERO_R0=1, reads of entry 0 SHALL return zero (bypass included), and writes to entry 0 SHALL be silently discarded without a wr_drop pulse.
REQ-022 States: IDLE and CLEAR; busy SHALL be high exactly in CLEAR.
REQ-023 IDLE -> CLEAR on clr_req high at an edge; the sweep counter SHALL load 0.
REQ-024 In CLEAR, each cycle SHALL zero the entry at the counter and increment it; on the cycle the counter equals DEPTH-1, that entry SHALL be zeroed and the state SHALL return to IDLE, giving exactly DEPTH busy cycles.
REQ-025 clr_req asserted while in CLEAR SHALL be ignored (no restart).
REQ-026 clr_req and wr_en in the same IDLE cycle: the write SHALL commit, and the sweep SHALL then zero it.
REQ-027 wr_en while busy SHALL discard the write and assert wr_drop for the next cycle; bypass SHALL be inactive while busy.
REQ-028 Reads during CLEAR SHALL return current storage: zero for entries already swept, old values otherwise.

Reset
REQ-029 At an edge with rst high, all entries SHALL become zero, the state SHALL be IDLE, the sweep counter 0, and wr_drop 0; busy SHALL be low in the following cycle.
REQ-030 rst SHALL override any in-progress sweep, pending write and clr_req in the same cycle.

Structure
REQ-031 A shared package SHALL hold the state enumeration (IDLE, CLEAR) and the default WIDTH/DEPTH constants.
REQ-032 One sub-module, reg_file_read_port (address decode, ZERO_R0 masking, bypass mux, enable gating), SHALL be instantiated twice.
REQ-033 Storage SHALL be a flat register array written only by the top-level sequential process.

Verification
REQ-034 Write 0xBEEF to entry 5; next cycle rd_en1=1, rd_addr1=5 -> rd_data1=0xBEEF; rd_en1=0 -> rd_data1=0x0000.
REQ-035 BYPASS=1: entry 3 holds 0x1111; write 0x2222 to entry 3 with rd_addr2=3 -> same-cycle rd_data2=0x2222; BYPASS=0 build -> 0x1111.
REQ-036 ZERO_R0=1: write 0xFFFF to entry 0 -> reads of entry 0 return 0x0000 both that cycle and after; wr_drop stays 0.
REQ-037 Fill all 16 entries, pulse clr_req -> busy high for exactly 16 cycles; reading entry 15 at busy cycle 10 returns old value; all entries zero after busy falls.
REQ-038 Write to entry 7 during cycle 4 of a sweep -> entry 7 ends zero, wr_drop high for exactly one cycle.
REQ-039 Assert rst at sweep cycle 8 -> busy low next cycle, all entries zero, a subsequent write and read proceed normally.
